// File: rtl/dcache_2way.sv
// dcache_2way: 2-way set-associative write-back, write-allocate data cache with LRU replacement.
// Define DCACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module dcache_2way #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);
  localparam int WOFF = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = ADDR_WIDTH - 2 - WOFF - IDX;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t                state_q, state_d;
  logic [WOFF-1:0]       beat_q, beat_d;
  logic                  victim_q, victim_d;
  logic [SETS-1:0][1:0]  valid_q, dirty_q;
  logic [SETS-1:0]       lru_q;
  logic [TAGW-1:0]       tag_q [SETS][2];
  logic [DATA_WIDTH-1:0] data_q [SETS][2][LINE_WORDS];
  logic [WOFF-1:0]       woff;
  logic [IDX-1:0]        idx;
  logic [TAGW-1:0]       tag;
  logic hit0, hit1, hit, hway, req, miss, lookup, vsel, last, fill, fill_done, unused_ok;
  assign woff      = cpu_addr[2 +: WOFF];
  assign idx       = cpu_addr[2+WOFF +: IDX];
  assign tag       = cpu_addr[ADDR_WIDTH-1 -: TAGW];
  assign unused_ok = ^cpu_addr[1:0];
  assign hit0      = valid_q[idx][0] && tag_q[idx][0] == tag;
  assign hit1      = valid_q[idx][1] && tag_q[idx][1] == tag;
  assign hit       = hit0 | hit1;
  assign hway      = ~hit0;
  assign req       = cpu_re | cpu_we;
  assign miss      = state_q == IDLE && req && !hit;
  // Covers both first-time hits and the replay after a refill
  assign lookup    = state_q == IDLE && req && hit;
  assign vsel      = !valid_q[idx][0] ? 1'b0 : !valid_q[idx][1] ? 1'b1 : lru_q[idx];
  assign last      = beat_q == WOFF'(LINE_WORDS - 1);
  assign fill      = state_q == REFILL && mem_ready;
  assign fill_done = fill && last;
  assign cpu_rdata = data_q[idx][hway][woff];
  assign mem_req   = state_q != IDLE;
  assign mem_we    = state_q == WRITEBACK;
  assign mem_addr  = {mem_we ? tag_q[idx][victim_q] : tag, idx, beat_q, 2'b00};
  assign mem_wdata = data_q[idx][victim_q][beat_q];
  // Held low during reset even though the CPU may still present a request
  assign stall     = rst && (state_q != IDLE || (req && !hit));
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    victim_d = victim_q;
    if (miss) begin
      victim_d = vsel;
      state_d  = valid_q[idx][vsel] && dirty_q[idx][vsel] ? WRITEBACK : REFILL;
    end else if (mem_req && mem_ready) begin
      beat_d  = beat_q + WOFF'(1);
      state_d = !last ? state_q : state_q == WRITEBACK ? REFILL : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      victim_q <= 1'b0;
      valid_q  <= '0;
      dirty_q  <= '0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      if (lookup) lru_q[idx] <= ~hway;
      if (lookup && cpu_we) dirty_q[idx][hway] <= 1'b1;
      if (fill_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (lookup && cpu_we) data_q[idx][hway][woff] <= cpu_wdata;
    if (fill) data_q[idx][victim_q][beat_q] <= mem_rdata;
    if (fill_done) tag_q[idx][victim_q] <= tag;
  end
`ifdef DCACHE_STATS_EN
  logic replay_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      replay_q <= 1'b0;
    end else begin
      replay_q <= fill_done;
      if (lookup && !replay_q) hit_cnt <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_2way.sv
// tb_dcache_2way: directed plus randomized checks of dcache_2way against a recency-list cache model
// and a flat word memory; stats counters are checked when DCACHE_STATS_EN is defined.
module tb_dcache_2way;
  logic        clk = 1'b0, rst = 1'b0, cpu_re = 1'b0, cpu_we = 1'b0, mem_ready = 1'b1;
  logic        stall, mem_req, mem_we;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0, cpu_rdata, mem_addr, mem_wdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int n_tests = 0, n_fail = 0;
  int mode = 0, wcnt = 0, age = 0, m_hits = 0, m_miss = 0;
  logic pv = 1'b0;
  logic [31:0] last_a = '0;
  typedef struct { logic we; logic [31:0] a; logic [31:0] d; int age; } beat_t;
  beat_t       beats[$];
  logic [31:0] backing [int unsigned];
  logic [31:0] truth [int unsigned];
  int unsigned rec [4][$];
  bit          dirty_l [int unsigned];

  dcache_2way dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return backing.exists(a) ? backing[a] : a;
  endfunction

  function automatic logic [31:0] cpu_view(input logic [31:0] a);
    return truth.exists(a) ? truth[a] : mem_rd(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory: read data and ready are presented from the falling edge
  always @(negedge clk) begin
    mem_rdata <= mem_rd(mem_addr);
    mem_ready <= mode == 0 ? 1'b1 : mode == 1 ? (mem_req && wcnt[0]) : ($urandom_range(0, 2) != 0);
    wcnt      <= mem_req ? wcnt + 1 : 0;
  end

  always @(posedge clk) begin
    if (rst && mem_req) begin
      age    = (pv && mem_addr == last_a) ? age + 1 : 1;
      pv     = 1'b1;
      last_a = mem_addr;
      if (mem_ready) begin
        beats.push_back('{mem_we, mem_addr, mem_wdata, age});
        if (mem_we) backing[mem_addr] = mem_wdata;
      end
    end else pv = 1'b0;
  end

  // Each set is a recency list of line numbers, most recent first
  function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                output int wb, output int miss, output int unsigned victim);
    int unsigned line = a >> 4;
    int s = int'(line % 4);
    int pos = -1;
    wb = 0; miss = 0; victim = 0;
    for (int i = 0; i < rec[s].size(); i++) if (rec[s][i] == line) pos = i;
    if (pos >= 0) begin
      rec[s].delete(pos);
      m_hits++;
    end else begin
      miss = 1;
      m_miss++;
      if (rec[s].size() == 2) begin
        victim = rec[s].pop_back();
        if (dirty_l.exists(victim)) begin
          wb = 1;
          dirty_l.delete(victim);
        end
      end
    end
    rec[s].push_front(line);
    if (we) begin
      truth[a & ~32'h3] = wd;
      dirty_l[line] = 1'b1;
    end
  endfunction

  task automatic run(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int wb, miss, cyc;
    int unsigned victim;
    logic [31:0] exp_rd, rd;
    exp_rd = cpu_view(a);
    model(we, a, wd, wb, miss, victim);
    @(negedge clk);
    cpu_we = we; cpu_re = !we; cpu_addr = a; cpu_wdata = wd;
    beats.delete();
    cyc = 0;
    #4;
    while (stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #4;
    end
    rd = cpu_rdata;
    chk("done", {31'b0, stall}, 0);
    if (!we) chk("rdata", rd, exp_rd);
    chk("beats", beats.size(), miss != 0 ? (wb != 0 ? 8 : 4) : 0);
    if (mode == 0) chk("stall_len", cyc, miss != 0 ? (wb != 0 ? 9 : 5) : 0);
    else if (mode == 1) chk("stall_len", cyc, miss != 0 ? (wb != 0 ? 17 : 9) : 0);
    else chk("stall_any", {31'b0, cyc != 0}, miss);
    if (wb != 0)
      for (int k = 0; k < 4; k++)
        if (truth.exists(victim * 16 + k * 4))
          chk("wb_data", mem_rd(victim * 16 + k * 4), truth[victim * 16 + k * 4]);
    @(posedge clk);
    #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] a;
    cpu_re = 1'b1; cpu_addr = 32'h100;
    #3;
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    cpu_re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run(1'b0, 32'h100, 0);
    if (beats.size() == 4)
      for (int k = 0; k < 4; k++) chk("cold_addr", beats[k].a, 32'h100 + 32'(k * 4));
    run(1'b0, 32'h104, 0);
    run(1'b1, 32'h104, 32'hDEADBEEF);
    run(1'b0, 32'h104, 0);
    run(1'b0, 32'h200, 0);
    run(1'b0, 32'h300, 0);
    if (beats.size() == 8) begin
      chk("wb0_addr", beats[0].a, 32'h100);
      chk("wb0_we", {31'b0, beats[0].we}, 1);
      chk("wb1_data", beats[1].d, 32'hDEADBEEF);
      chk("wb3_addr", beats[3].a, 32'h10C);
      chk("rf0_addr", beats[4].a, 32'h300);
      chk("rf0_we", {31'b0, beats[4].we}, 0);
      chk("rf3_addr", beats[7].a, 32'h30C);
    end
    run(1'b0, 32'h200, 0);
    mode = 1;
    run(1'b0, 32'h410, 0);
    foreach (beats[k]) chk("hold", beats[k].age, 2);
    mode = 0;
    // Reset while refill beat 2 of 0x500 is on the bus
    @(negedge clk);
    cpu_re = 1'b1; cpu_addr = 32'h500;
    cyc = 0;
    while (!(mem_req && !mem_we && mem_addr == 32'h508) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("beat2_addr", mem_addr, 32'h508);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_req", {31'b0, mem_req}, 0);
    chk("abort_stall", {31'b0, stall}, 0);
    cpu_re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    foreach (rec[i]) rec[i].delete();
    dirty_l.delete();
    truth.delete();
    m_hits = 0; m_miss = 0;
    run(1'b0, 32'h200, 0);
    run(1'b0, 32'h204, 0);
    run(1'b1, 32'h208, 32'h12345678);
    run(1'b0, 32'h20C, 0);
    run(1'b0, 32'h600, 0);
`ifdef DCACHE_STATS_EN
    chk("hit_cnt", hit_cnt, 3);
    chk("miss_cnt", miss_cnt, 2);
`endif
    for (int n = 0; n < 300; n++) begin
      mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        #4;
        chk("idle_stall", {31'b0, stall}, 0);
        chk("idle_req", {31'b0, mem_req}, 0);
      end
      a = {22'h0, 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      run(1'($urandom_range(0, 1)), a, $urandom);
    end
`ifdef DCACHE_STATS_EN
    chk("hit_cnt_rand", hit_cnt, m_hits);
    chk("miss_cnt_rand", miss_cnt, m_miss);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
